obstacle_runner: RTL and testbench
==================================

Name: obstacle_runner

Overview:
- Upstream stage of the game-control FSM: produces its `collided` and `reached_screen_end` inputs.
- Scrolls a single obstacle right-to-left across the screen once per frame tick.
- Runs the player jump arc from the `user_input` button.
- Detects player/obstacle overlap and counts obstacles cleared; the level ends after LEVEL_LEN obstacles.

Parameters:
- SCREEN_W, 640, obstacle spawn column is SCREEN_W-1; x is 10 bits
- PLAYER_X, 64, left column of player hitbox
- PLAYER_W, 16, player hitbox width in columns
- OBST_W, 8, obstacle width in columns
- OBST_H, 20, obstacle height; player y < OBST_H is low enough to hit
- JUMP_H, 48, apex height (y is 7 bits, JUMP_H ≤ 127)
- JUMP_STEP, 4, y change per frame tick
- SPEED, 2, obstacle columns moved per frame tick (base speed)
- LEVEL_LEN, 10, obstacles to clear for a win; counter is 8 bits

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse: re-initialise the playfield for a new run
- run  in  1  high while the game FSM is in CONTINUE; gates all motion
- frame_tick  in  1  1-cycle pulse per video frame
- user_input  in  1  jump button level
- obst_x  out  10  obstacle left column
- player_y  out  7  player height above ground
- passed  out  8  obstacles cleared this run
- collided  out  1  sticky level; overlap detected
- reached_screen_end  out  1  sticky level; LEVEL_LEN obstacles cleared

Behaviour:
- Reset and start are identical and take effect on the next clock edge. Resulting values:
  - obst_x = SCREEN_W-1, player_y = 0, passed = 0
  - collided = 0, reached_screen_end = 0
  - jump state = GROUND; speed = SPEED
  - reset has priority over start; both abort any jump or scroll in progress.
- Freeze condition: `frozen = collided | reached_screen_end`. While `!run` or frozen, all state holds and frame_tick is ignored.
- Obstacle scroll (on frame_tick, when active):
  - If obst_x < speed (wrap): obst_x <= SCREEN_W-1 and passed <= passed+1.
  - Otherwise obst_x <= obst_x - speed.
- Level end: when the wrap makes passed reach LEVEL_LEN, reached_screen_end sets on that same edge and motion freezes.
- Jump FSM, states GROUND, RISE, FALL:
  - GROUND: if user_input is high on an active frame_tick, go to RISE. y is unchanged that tick.
  - RISE: on each active tick, y <= min(y+JUMP_STEP, JUMP_H). When the result equals JUMP_H, go to FALL.
  - FALL: on each active tick, y <= max(y-JUMP_STEP, 0). When the result equals 0, go to GROUND.
  - user_input is ignored in RISE and FALL; there is no double jump. A held button re-jumps on the first tick after landing.
- Collision is evaluated every clock from registered obst_x and player_y while `run && !frozen`.
  - Overlap test: `obst_x < PLAYER_X+PLAYER_W && obst_x+OBST_W > PLAYER_X && player_y < OBST_H`.
  - Use 11-bit sums so the comparison cannot overflow.
  - On overlap, collided sets on the next edge (1-cycle latency from position update).
- Simultaneous events: if overlap and the final wrap occur on the same edge, collided sets and reached_screen_end does not. The FSM sees a loss.
- collided and reached_screen_end never assert together. Both clear only on reset or start.

Optional Feature:
- Macro: OBSTACLE_RUNNER_SPEEDUP_EN.
- Defined: on each wrap where the new passed is a nonzero multiple of 4, speed <= min(speed+1, 2*SPEED). The new speed applies from the next tick.
- Undefined: speed is fixed at SPEED; no speed register is synthesised.

Decomposition:
- Shared package `game_pkg`:
  - screen geometry constants (SCREEN_W, x/y widths)
  - jump state typedef (GROUND/RISE/FALL)
  - LEVEL_LEN default
- Natural sub-module: `jump_ctrl`. It holds the jump FSM and the player_y register. Inputs: tick_en, user_input, clear. Output: player_y.
- Scroll logic, counter and collision logic stay in the top module.

Test Plan:
- Reset then start, run=1, 10 ticks, no jump → obst_x 639→619; passed=0; collided=0.
- No jump, default parameters:
  - collided=1 exactly 1 cycle after obst_x first falls below 80 (obst_x=79).
  - After that, obst_x and player_y hold for 20 further ticks.
- user_input high in GROUND:
  - y goes 0,4,…,48, then down to 0 over 24 ticks.
  - With correctly timed jumps, the obstacle passes under (y ≥ 20) → collided stays 0.
- LEVEL_LEN=2, OBST_H=0 (no hits possible):
  - reached_screen_end=1 on the edge where passed becomes 2.
  - Motion then freezes; start clears all state.
- run=0 for 50 ticks mid-jump → y and obst_x unchanged. Raising run resumes from the same values.
- With OBSTACLE_RUNNER_SPEEDUP_EN: speed goes 2→3 after passed=4, then 3→4 after passed=8, then saturates at 4.

Source files
------------

// File: rtl/game_pkg.sv
// Shared geometry, widths and jump-state type for the obstacle runner playfield.
package game_pkg;
    localparam int unsigned X_W            = 10;
    localparam int unsigned Y_W            = 7;
    localparam int unsigned CNT_W          = 8;
    localparam int unsigned SUM_W          = X_W + 1;
    localparam int unsigned SCREEN_W_DFLT  = 640;
    localparam int unsigned LEVEL_LEN_DFLT = 10;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;
endpackage

// File: rtl/jump_ctrl.sv
// Player jump arc: GROUND -> RISE -> FALL -> GROUND, one height step per enabled tick.
module jump_ctrl
    import game_pkg::*;
#(
    parameter int unsigned JUMP_H    = 48,
    parameter int unsigned JUMP_STEP = 4
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           tick_en,
    input  logic           user_input,
    output logic [Y_W-1:0] player_y
);
    localparam int unsigned YE_W = Y_W + 1;

    jump_state_t     state;
    jump_state_t     state_next;
    logic [Y_W-1:0]  y_next;
    logic [YE_W-1:0] y_up;

    // one extra bit so the rising sum cannot wrap before the apex clamp
    assign y_up = {1'b0, player_y} + YE_W'(JUMP_STEP);

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= GROUND;
            player_y <= '0;
        end else begin
            state    <= state_next;
            player_y <= y_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tick_en) begin
            case (state)
                GROUND:  if (user_input) state_next = RISE;
                RISE:    if (y_next == Y_W'(JUMP_H)) state_next = FALL;
                FALL:    if (y_next == '0) state_next = GROUND;
                default: state_next = GROUND;
            endcase
        end
    end

    always_comb begin
        y_next = player_y;
        if (tick_en) begin
            case (state)
                RISE:    y_next = (y_up >= YE_W'(JUMP_H)) ? Y_W'(JUMP_H) : y_up[Y_W-1:0];
                FALL:    y_next = (player_y <= Y_W'(JUMP_STEP)) ? '0 : player_y - Y_W'(JUMP_STEP);
                default: y_next = player_y;
            endcase
        end
    end
endmodule

// File: rtl/obstacle_runner.sv
// Obstacle scroll, pass counter and collision detect feeding the game-control FSM.
// Optional per-4-obstacle speed-up enabled by defining OBSTACLE_RUNNER_SPEEDUP_EN.
module obstacle_runner
    import game_pkg::*;
#(
    parameter int unsigned SCREEN_W  = SCREEN_W_DFLT,
    parameter int unsigned PLAYER_X  = 64,
    parameter int unsigned PLAYER_W  = 16,
    parameter int unsigned OBST_W    = 8,
    parameter int unsigned OBST_H    = 20,
    parameter int unsigned JUMP_H    = 48,
    parameter int unsigned JUMP_STEP = 4,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned LEVEL_LEN = LEVEL_LEN_DFLT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             frame_tick,
    input  logic             user_input,
    output logic [X_W-1:0]   obst_x,
    output logic [Y_W-1:0]   player_y,
    output logic [CNT_W-1:0] passed,
    output logic             collided,
    output logic             reached_screen_end
);
    logic             clear;
    logic             frozen;
    logic             active;
    logic             tick_en;
    logic             wrap;
    logic             overlap;
    logic [X_W-1:0]   speed;
    logic [CNT_W-1:0] passed_next;
    logic [SUM_W-1:0] x_ext;

    assign clear       = reset | start;
    assign frozen      = collided | reached_screen_end;
    assign active      = run & ~frozen;
    assign tick_en     = active & frame_tick;
    assign wrap        = obst_x < speed;
    assign passed_next = passed + CNT_W'(1);
    assign x_ext       = {1'b0, obst_x};

    // hitbox overlap on registered positions, sums kept one bit wider than x
    assign overlap = (x_ext < SUM_W'(PLAYER_X + PLAYER_W))
                  && ((x_ext + SUM_W'(OBST_W)) > SUM_W'(PLAYER_X))
                  && (32'(player_y) < OBST_H);

`ifdef OBSTACLE_RUNNER_SPEEDUP_EN
    logic [X_W-1:0] speed_inc;
    assign speed_inc = speed + X_W'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            speed <= X_W'(SPEED);
        end else if (tick_en && wrap && (passed_next != '0) && (passed_next[1:0] == 2'b00)) begin
            speed <= (speed_inc > X_W'(2 * SPEED)) ? X_W'(2 * SPEED) : speed_inc;
        end
    end
`else
    assign speed = X_W'(SPEED);
`endif

    // a loss on the final-wrap edge wins over the level end
    always_ff @(posedge clock) begin
        if (clear) begin
            obst_x             <= X_W'(SCREEN_W - 1);
            passed             <= '0;
            collided           <= 1'b0;
            reached_screen_end <= 1'b0;
        end else begin
            if (active && overlap) begin
                collided <= 1'b1;
            end
            if (tick_en) begin
                if (wrap) begin
                    obst_x <= X_W'(SCREEN_W - 1);
                    passed <= passed_next;
                    if ((passed_next == CNT_W'(LEVEL_LEN)) && !overlap) begin
                        reached_screen_end <= 1'b1;
                    end
                end else begin
                    obst_x <= obst_x - speed;
                end
            end
        end
    end

    jump_ctrl #(
        .JUMP_H    (JUMP_H),
        .JUMP_STEP (JUMP_STEP)
    ) u_jump_ctrl (
        .clock      (clock),
        .clear      (clear),
        .tick_en    (tick_en),
        .user_input (user_input),
        .player_y   (player_y)
    );
endmodule

// File: tb/tb_obstacle_runner.sv
// Self-checking bench: three obstacle_runner instances against a per-instance reference model.
module tb_obstacle_runner;
    logic       clock;
    logic       reset;
    logic       st [3];
    logic       rn [3];
    logic       tk [3];
    logic       ui [3];
    logic [9:0] ox [3];
    logic [6:0] py [3];
    logic [7:0] ps [3];
    logic       co [3];
    logic       fn [3];

    int n_checks;
    int n_errors;

    localparam int OH [3] = '{20, 0, 0};
    localparam int LL [3] = '{10, 2, 10};

    typedef struct {
        int x;
        int y;
        int js;      // 0 on ground, 1 going up, 2 coming down
        int passed;
        bit col;
        bit fin;
    } mdl_t;

    mdl_t mdl [3];

    obstacle_runner u_a (
        .clock(clock), .reset(reset), .start(st[0]), .run(rn[0]), .frame_tick(tk[0]),
        .user_input(ui[0]), .obst_x(ox[0]), .player_y(py[0]), .passed(ps[0]),
        .collided(co[0]), .reached_screen_end(fn[0]));

    obstacle_runner #(.LEVEL_LEN(2), .OBST_H(0)) u_b (
        .clock(clock), .reset(reset), .start(st[1]), .run(rn[1]), .frame_tick(tk[1]),
        .user_input(ui[1]), .obst_x(ox[1]), .player_y(py[1]), .passed(ps[1]),
        .collided(co[1]), .reached_screen_end(fn[1]));

    obstacle_runner #(.OBST_H(0)) u_c (
        .clock(clock), .reset(reset), .start(st[2]), .run(rn[2]), .frame_tick(tk[2]),
        .user_input(ui[2]), .obst_x(ox[2]), .player_y(py[2]), .passed(ps[2]),
        .collided(co[2]), .reached_screen_end(fn[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game rules in plain integer arithmetic; speed derives from how many obstacles were passed.
    function automatic mdl_t mstep(mdl_t m, bit clr, bit run_i, bit tick_i, bit btn, int oh, int ll);
        mdl_t n;
        bit   ov;
        int   spd;
        n = m;
        if (clr) begin
            n.x = 639; n.y = 0; n.js = 0; n.passed = 0; n.col = 0; n.fin = 0;
            return n;
        end
        if (!run_i || m.col || m.fin) return n;
        ov = (m.x < 64 + 16) && (m.x + 8 > 64) && (m.y < oh);
`ifdef OBSTACLE_RUNNER_SPEEDUP_EN
        spd = 2 + m.passed / 4;
        if (spd > 4) spd = 4;
`else
        spd = 2;
`endif
        if (tick_i) begin
            if (m.x < spd) begin
                n.x = 639;
                n.passed = (m.passed + 1) % 256;
                if (n.passed == ll && !ov) n.fin = 1;
            end else begin
                n.x = m.x - spd;
            end
            if (m.js == 0) begin
                if (btn) n.js = 1;
            end else if (m.js == 1) begin
                n.y = (m.y + 4 > 48) ? 48 : m.y + 4;
                if (n.y == 48) n.js = 2;
            end else begin
                n.y = (m.y - 4 < 0) ? 0 : m.y - 4;
                if (n.y == 0) n.js = 0;
            end
        end
        if (ov) n.col = 1;
        return n;
    endfunction

    task automatic check_all(input int k);
        check($sformatf("obst_x[%0d]", k), int'(ox[k]), mdl[k].x);
        check($sformatf("player_y[%0d]", k), int'(py[k]), mdl[k].y);
        check($sformatf("passed[%0d]", k), int'(ps[k]), mdl[k].passed);
        check($sformatf("collided[%0d]", k), int'(co[k]), int'(mdl[k].col));
        check($sformatf("reached_end[%0d]", k), int'(fn[k]), int'(mdl[k].fin));
    endtask

    // one clock on instance k; the other instances idle with run low
    task automatic step(input int k, input bit s, input bit r, input bit t, input bit u);
        st[k] = s; rn[k] = r; tk[k] = t; ui[k] = u;
        @(posedge clock);
        mdl[k] = mstep(mdl[k], s, r, t, u, OH[k], LL[k]);
        #1;
        check_all(k);
        st[k] = 1'b0;
        tk[k] = 1'b0;
    endtask

    task automatic ticks(input int k, input int n, input bit u);
        for (int i = 0; i < n; i++) step(k, 1'b0, 1'b1, 1'b1, u);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; rn[k] = 1'b0; tk[k] = 1'b0; ui[k] = 1'b0;
            mdl[k] = '{x: 0, y: 0, js: 0, passed: 0, col: 1'b0, fin: 1'b0};
        end
        reset = 1'b1;
        @(posedge clock);
        for (int k = 0; k < 3; k++) mdl[k] = mstep(mdl[k], 1'b1, 1'b0, 1'b0, 1'b0, OH[k], LL[k]);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) check_all(k);

        // plain scroll, then the first collision with no jump
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(0, 10, 1'b0);
        check("scroll10_x", int'(ox[0]), 619);
        check("scroll10_passed", int'(ps[0]), 0);
        ticks(0, 270, 1'b0);
        check("pre_hit_x", int'(ox[0]), 79);
        check("pre_hit_col", int'(co[0]), 0);
        ticks(0, 1, 1'b0);
        check("hit_col", int'(co[0]), 1);
        check("hit_x", int'(ox[0]), 77);
        ticks(0, 20, 1'b0);
        check("frozen_x", int'(ox[0]), 77);
        check("frozen_y", int'(py[0]), 0);

        // full jump arc
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(0, 1, 1'b1);
        check("launch_y", int'(py[0]), 0);
        ticks(0, 12, 1'b0);
        check("apex_y", int'(py[0]), 48);
        ticks(0, 12, 1'b0);
        check("landed_y", int'(py[0]), 0);

        // jump launched at x=95 clears the obstacle
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(0, 272, 1'b0);
        check("timed_x", int'(ox[0]), 95);
        ticks(0, 1, 1'b1);
        ticks(0, 40, 1'b0);
        check("timed_no_col", int'(co[0]), 0);
        check("timed_x_after", int'(ox[0]), 13);

        // run low mid-jump holds everything
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(0, 1, 1'b1);
        ticks(0, 5, 1'b0);
        for (int i = 0; i < 50; i++) step(0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_y", int'(py[0]), 20);
        check("pause_x", int'(ox[0]), 627);
        ticks(0, 1, 1'b0);
        check("resume_y", int'(py[0]), 24);
        check("resume_x", int'(ox[0]), 625);
        rn[0] = 1'b0;

        // short level with no hits possible
        step(1, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(1, 639, 1'b0);
        check("lvl_x", int'(ox[1]), 1);
        check("lvl_passed1", int'(ps[1]), 1);
        check("lvl_fin0", int'(fn[1]), 0);
        ticks(1, 1, 1'b0);
        check("lvl_passed2", int'(ps[1]), 2);
        check("lvl_fin1", int'(fn[1]), 1);
        ticks(1, 5, 1'b0);
        check("lvl_frozen_x", int'(ox[1]), 639);
        step(1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lvl_start_fin", int'(fn[1]), 0);
        check("lvl_start_passed", int'(ps[1]), 0);
        rn[1] = 1'b0;

        // random play with collisions possible
        for (int i = 0; i < 3000; i++)
            step(0, ($urandom_range(199) == 0), ($urandom_range(9) != 0),
                 ($urandom_range(1) == 1), ($urandom_range(3) == 0));
        rn[0] = 1'b0;

        // long random play without collisions, reaching many wraps
        step(2, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12000; i++)
            step(2, ($urandom_range(5999) == 0), ($urandom_range(9) != 0),
                 ($urandom_range(3) != 0), ($urandom_range(2) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
